// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I control FSM with memory-ready stall and aludec
module aludec (
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);
  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      2'b00: alucontrol = 3'b000;
      2'b01: alucontrol = 3'b001;
      default: begin
        case (funct3)
          3'b000:  alucontrol = (opb5 & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
    endcase
  end
endmodule

module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       illegal_instr,
  output logic       instr_retire,
  output logic [3:0] state
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3;
  localparam logic [3:0] MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, ALUWB = 4'd7;
  localparam logic [3:0] EXECI = 4'd8, JAL = 4'd9, BEQ = 4'd10, LUIWB = 4'd11;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic [3:0] next_state;
  logic [1:0] aluop;
  logic       pcupdate, branch, irwrite_raw, memwrite_raw, regwrite_raw;
  logic       illegal_raw, retire_raw;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= RESET_STATE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:    next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECR;
          OP_I:         next_state = EXECI;
          OP_JAL:       next_state = JAL;
          OP_BEQ:       next_state = BEQ;
          OP_LUI:       next_state = LUIWB;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state = mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: next_state = mem_ready ? FETCH : MEMWRITE;
      EXECR, EXECI, JAL: next_state = ALUWB;
      default:  next_state = FETCH;
    endcase
  end

  always_comb begin
    AdrSrc       = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    aluop        = 2'b00;
    pcupdate     = 1'b0;
    branch       = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    illegal_raw  = 1'b0;
    retire_raw   = 1'b0;
    ImmSrc       = 3'b000;
    if (state <= LUIWB) begin
      case (op)
        OP_SW:   ImmSrc = 3'b001;
        OP_BEQ:  ImmSrc = 3'b010;
        OP_JAL:  ImmSrc = 3'b011;
        OP_LUI:  ImmSrc = 3'b100;
        default: ImmSrc = 3'b000;
      endcase
    end
    case (state)
      FETCH: begin
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        irwrite_raw = mem_ready;
        pcupdate    = mem_ready;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ, OP_LUI: illegal_raw = 1'b0;
          default: illegal_raw = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc    = 2'b01;
        regwrite_raw = 1'b1;
        retire_raw   = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc       = 1'b1;
        memwrite_raw = 1'b1;
        retire_raw   = mem_ready;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluop   = 2'b10;
      end
      ALUWB, LUIWB: begin
        ResultSrc    = (state == LUIWB) ? 2'b11 : 2'b00;
        regwrite_raw = 1'b1;
        retire_raw   = 1'b1;
      end
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcupdate = 1'b1;
      end
      BEQ: begin
        ALUSrcA    = 2'b10;
        aluop      = 2'b01;
        branch     = 1'b1;
        retire_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables and pulses are suppressed during reset so an aborted instruction leaves no side effects
  assign PCWrite       = reset_n & ((branch & Zero) | pcupdate);
  assign IRWrite       = reset_n & irwrite_raw;
  assign MemWrite      = reset_n & memwrite_raw;
  assign RegWrite      = reset_n & regwrite_raw;
  assign illegal_instr = reset_n & illegal_raw;
  assign instr_retire  = reset_n & retire_raw;

  aludec u_aludec (
    .opb5       (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .aluop      (aluop),
    .alucontrol (ALUControl)
  );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller with directed instruction sequences
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       reset_n, Zero, mem_ready, funct7b5;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr, instr_retire;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUControl;
  logic [3:0] state;

  typedef struct {
    string       name;
    logic [22:0] v;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  multicycle_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl),
    .illegal_instr(illegal_instr), .instr_retire(instr_retire), .state(state)
  );

  always #5 clk = ~clk;

  // Fields: state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegWrite, ALUControl, illegal, retire
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [22:0] got;
      e   = q.pop_front();
      got = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ImmSrc, RegWrite, ALUControl, illegal_instr, instr_retire};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s: got st=%0d pcw=%b adr=%b mw=%b irw=%b rs=%b sa=%b sb=%b imm=%b rw=%b alc=%b ill=%b ret=%b, exp st=%0d pcw=%b adr=%b mw=%b irw=%b rs=%b sa=%b sb=%b imm=%b rw=%b alc=%b ill=%b ret=%b",
                 e.name, got[22:19], got[18], got[17], got[16], got[15], got[14:13], got[12:11],
                 got[10:9], got[8:6], got[5], got[4:2], got[1], got[0],
                 e.v[22:19], e.v[18], e.v[17], e.v[16], e.v[15], e.v[14:13], e.v[12:11],
                 e.v[10:9], e.v[8:6], e.v[5], e.v[4:2], e.v[1], e.v[0]);
      end
    end
  end

  task automatic exp(input string n, input logic [3:0] st, input logic pcw, adr, mw, irw,
                     input logic [1:0] rs, sa, sb, input logic [2:0] imm, input logic rw,
                     input logic [2:0] alc, input logic ill, ret);
    exp_t e;
    e.name = n;
    e.v    = {st, pcw, adr, mw, irw, rs, sa, sb, imm, rw, alc, ill, ret};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string n, input logic [2:0] imm);
    exp(n, 4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, 0, 3'b000, 0, 0);
  endtask

  task automatic decode(input string n, input logic [2:0] imm, input logic ill);
    exp(n, 4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 0, 3'b000, ill, 0);
  endtask

  task automatic setop(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  initial begin
    reset_n = 1'b0; mem_ready = 1'b1; Zero = 1'b0;
    setop(7'b0100011, 3'b010, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    exp("reset_fetch", 4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b001, 0, 3'b000, 0, 0);
    reset_n = 1'b1;

    // sw with three stall cycles in MEMWRITE
    fetch("sw_f", 3'b001);
    decode("sw_d", 3'b001, 0);
    exp("sw_madr", 4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 0, 3'b000, 0, 0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      exp("sw_wait", 4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b001, 0, 3'b000, 0, 0);
    mem_ready = 1'b1;
    exp("sw_done", 4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b001, 0, 3'b000, 0, 1);

    // sw aborted by reset while in MEMWRITE
    fetch("sw2_f", 3'b001);
    decode("sw2_d", 3'b001, 0);
    exp("sw2_madr", 4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 0, 3'b000, 0, 0);
    mem_ready = 1'b0;
    exp("sw2_mw", 4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b001, 0, 3'b000, 0, 0);
    reset_n = 1'b0;
    exp("rst_in_mw", 4'd5, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, 0, 3'b000, 0, 0);
    exp("rst_fetch", 4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b001, 0, 3'b000, 0, 0);
    reset_n = 1'b1;

    // lw with one stall cycle in FETCH
    setop(7'b0000011, 3'b010, 1'b0);
    exp("lw_fstall", 4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 3'b000, 0, 0);
    mem_ready = 1'b1;
    fetch("lw_f", 3'b000);
    decode("lw_d", 3'b000, 0);
    exp("lw_madr", 4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 3'b000, 0, 0);
    exp("lw_mread", 4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 3'b000, 0, 0);
    exp("lw_memwb", 4'd4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 1, 3'b000, 0, 1);

    // beq taken then not taken
    setop(7'b1100011, 3'b000, 1'b0);
    Zero = 1'b1;
    fetch("beq1_f", 3'b010);
    decode("beq1_d", 3'b010, 0);
    exp("beq_taken", 4'd10, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 0, 3'b001, 0, 1);
    Zero = 1'b0;
    fetch("beq2_f", 3'b010);
    decode("beq2_d", 3'b010, 0);
    exp("beq_nottaken", 4'd10, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 0, 3'b001, 0, 1);

    // R-type add then sub
    setop(7'b0110011, 3'b000, 1'b0);
    fetch("add_f", 3'b000);
    decode("add_d", 3'b000, 0);
    exp("add_exec", 4'd6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 0, 3'b000, 0, 0);
    exp("add_wb", 4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 3'b000, 0, 1);
    setop(7'b0110011, 3'b000, 1'b1);
    fetch("sub_f", 3'b000);
    decode("sub_d", 3'b000, 0);
    exp("sub_exec", 4'd6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 0, 3'b001, 0, 0);
    exp("sub_wb", 4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 3'b000, 0, 1);

    // addi with instr[30] set stays add; then or-immediate
    setop(7'b0010011, 3'b000, 1'b1);
    fetch("addi_f", 3'b000);
    decode("addi_d", 3'b000, 0);
    exp("addi_exec", 4'd8, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 3'b000, 0, 0);
    exp("addi_wb", 4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 3'b000, 0, 1);
    setop(7'b0010011, 3'b110, 1'b0);
    fetch("ori_f", 3'b000);
    decode("ori_d", 3'b000, 0);
    exp("ori_exec", 4'd8, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 3'b011, 0, 0);
    exp("ori_wb", 4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 3'b000, 0, 1);

    // jal and lui
    setop(7'b1101111, 3'b000, 1'b0);
    fetch("jal_f", 3'b011);
    decode("jal_d", 3'b011, 0);
    exp("jal_exec", 4'd9, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b011, 0, 3'b000, 0, 0);
    exp("jal_wb", 4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b011, 1, 3'b000, 0, 1);
    setop(7'b0110111, 3'b000, 1'b0);
    fetch("lui_f", 3'b100);
    decode("lui_d", 3'b100, 0);
    exp("lui_wb", 4'd11, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 3'b100, 1, 3'b000, 0, 1);

    // unsupported opcode
    setop(7'b1111111, 3'b000, 1'b0);
    fetch("ill_f", 3'b000);
    decode("ill_d", 3'b000, 1);
    mem_ready = 1'b0;
    exp("ill_back", 4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 3'b000, 0, 0);

    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, exp 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
